xnor_psum_accumulator: RTL

Parametrised channel accumulator placed between the XNOR convolution PE array and the output-activation writer. It sums the per-pixel partial sums of every input channel in a local buffer and binarises each pixel against a per-output-channel threshold with selectable polarity. Feature-map size and channel count are set at run time, and the output side supports back-pressure.

---
 rtl/xnor_psum_accumulator_pkg.sv | 27 ++
 rtl/xnor_psum_accumulator_if.sv | 13 +
 rtl/xnor_psum_accumulator_psum_buffer.sv | 24 ++
 rtl/xnor_psum_accumulator.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/xnor_psum_accumulator_pkg.sv
// xnor_conv_pkg: shared state encoding, width defaults and saturating add for the XNOR conv datapath
package xnor_conv_pkg;
    localparam int PSUM_W_DEF  = 5;
    localparam int ACC_W_DEF   = 14;
    localparam int MAX_PIX_DEF = 1024;
    localparam int MAX_CH_DEF  = 256;
    localparam int THR_W_DEF   = 14;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic              sat;
        logic signed [31:0] sum;
    } sat_res_t;

    // Operands must already fit in w bits; the 33-bit sum cannot overflow before clamping.
    function automatic sat_res_t sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
        logic signed [32:0] s, hi, lo;
        sat_res_t r;
        s = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        r.sat = s > hi || s < lo;
        r.sum = 32'(s > hi ? hi : s < lo ? lo : s);
        return r;
    endfunction
endpackage

// File: rtl/xnor_psum_accumulator_if.sv
// xnor_psum_accumulator_if: partial-sum input stream and binarised output stream
interface xnor_psum_accumulator_if #(parameter int PSUM_W = 5);
    logic                     psum_valid;
    logic                     psum_ready;
    logic signed [PSUM_W-1:0] psum_in;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_bit;
    logic                     out_last;

    modport master (output psum_valid, psum_in, out_ready, input psum_ready, out_valid, out_bit, out_last);
    modport slave  (input psum_valid, psum_in, out_ready, output psum_ready, out_valid, out_bit, out_last);
endinterface

// File: rtl/xnor_psum_accumulator_psum_buffer.sv
// psum_buffer: simple dual-port synchronous RAM, one-cycle read latency, no reset (block-RAM friendly)
module psum_buffer #(
    parameter int W  = 14,
    parameter int D  = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [D];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/xnor_psum_accumulator.sv
// xnor_psum_accumulator: sums per-pixel partial sums over input channels and binarises
// each pixel against a per-output-channel threshold, with output back-pressure.
module xnor_psum_accumulator
    import xnor_conv_pkg::*;
#(
    parameter int PSUM_W  = PSUM_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_PIX = MAX_PIX_DEF,
    parameter int MAX_CH  = MAX_CH_DEF,
    parameter int THR_W   = THR_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [$clog2(MAX_PIX+1)-1:0]   cfg_num_pix,
    input  logic [$clog2(MAX_CH+1)-1:0]    cfg_num_ch,
    input  logic signed [THR_W-1:0]        threshold,
    input  logic                           thr_invert,
    xnor_psum_accumulator_if.slave         bus,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_flag
);
    localparam int PW = $clog2(MAX_PIX + 1);
    localparam int CW = $clog2(MAX_CH + 1);
    localparam int AW = MAX_PIX > 1 ? $clog2(MAX_PIX) : 1;

    typedef struct packed {
        logic              vld;
        logic              first;
        logic              last_ch;
        logic              last;
        logic [PW-1:0]     pix;
        logic [PSUM_W-1:0] psum;
    } s1_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            num_pix_q, num_pix_d, pix_q, pix_d, fw_pix_q, fw_pix_d;
    logic [CW-1:0]            num_ch_q, num_ch_d, ch_q, ch_d;
    logic signed [THR_W-1:0]  thr_q, thr_d;
    logic                     inv_q, inv_d;
    s1_t                      s1_q, s1_d;
    logic                     fw_vld_q, fw_vld_d;
    logic signed [ACC_W-1:0]  fw_acc_q, fw_acc_d;
    logic                     out_valid_q, out_valid_d, out_bit_q, out_bit_d, out_last_q, out_last_d;
    logic                     done_q, done_d, sat_q, sat_d;
    logic                     start_go, stall, accept, pix_wrap, ch_last, emit, out_xfer, bit_v, we;
    logic signed [ACC_W-1:0]  rd_data, base, acc;
    sat_res_t                 sr;

    psum_buffer #(.W(ACC_W), .D(MAX_PIX), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (s1_q.pix[AW-1:0]),
        .wdata (acc),
        .re    (!stall),
        .raddr (pix_q[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (start ? RUN : IDLE)
                : state_q == RUN  ? (accept && ch_last && pix_wrap ? DRAIN : RUN)
                : (out_xfer && out_last_q ? IDLE : DRAIN);
    end

    always_comb begin
        busy = state_q != IDLE;
        bus.psum_ready = state_q == RUN && !stall;
    end

    always_comb begin
        start_go = state_q == IDLE && start;
        stall = out_valid_q && !bus.out_ready;
        out_xfer = out_valid_q && bus.out_ready;
        accept = bus.psum_valid && bus.psum_ready;
        pix_wrap = pix_q == num_pix_q - PW'(1);
        ch_last = ch_q == num_ch_q - CW'(1);
        // The previous stage-2 write lands on the same edge as this read, so it is taken from fw_* instead.
        base = s1_q.first ? '0 : (fw_vld_q && fw_pix_q == s1_q.pix) ? fw_acc_q : rd_data;
        sr = sat_add(32'(base), 32'($signed(s1_q.psum)), ACC_W);
        acc = ACC_W'($signed(sr.sum));
        bit_v = inv_q ^ (acc >= ACC_W'(thr_q));
        emit = s1_q.vld && s1_q.last_ch;
        we = s1_q.vld && !stall && !s1_q.last_ch;
        num_pix_d = start_go ? cfg_num_pix : num_pix_q;
        num_ch_d = start_go ? cfg_num_ch : num_ch_q;
        thr_d = start_go ? threshold : thr_q;
        inv_d = start_go ? thr_invert : inv_q;
        pix_d = start_go ? '0 : accept ? (pix_wrap ? '0 : pix_q + PW'(1)) : pix_q;
        ch_d = start_go ? '0 : accept && pix_wrap ? ch_q + CW'(1) : ch_q;
        s1_d = s1_q;
        if (!stall) begin
            s1_d.vld = accept;
            s1_d.first = ch_q == '0;
            s1_d.last_ch = ch_last;
            s1_d.last = ch_last && pix_wrap;
            s1_d.pix = pix_q;
            s1_d.psum = bus.psum_in;
        end
        fw_vld_d = stall ? fw_vld_q : we;
        fw_pix_d = stall ? fw_pix_q : s1_q.pix;
        fw_acc_d = stall ? fw_acc_q : acc;
        out_valid_d = stall ? out_valid_q : emit;
        out_bit_d = stall ? out_bit_q : emit && bit_v;
        out_last_d = stall ? out_last_q : emit && s1_q.last;
        sat_d = start_go ? 1'b0 : sat_q || (s1_q.vld && !stall && sr.sat);
        done_d = state_q == DRAIN && out_xfer && out_last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_pix_q   <= '0;
            num_ch_q    <= '0;
            thr_q       <= '0;
            inv_q       <= 1'b0;
            pix_q       <= '0;
            ch_q        <= '0;
            s1_q        <= '0;
            fw_vld_q    <= 1'b0;
            fw_pix_q    <= '0;
            fw_acc_q    <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            num_pix_q   <= num_pix_d;
            num_ch_q    <= num_ch_d;
            thr_q       <= thr_d;
            inv_q       <= inv_d;
            pix_q       <= pix_d;
            ch_q        <= ch_d;
            s1_q        <= s1_d;
            fw_vld_q    <= fw_vld_d;
            fw_pix_q    <= fw_pix_d;
            fw_acc_q    <= fw_acc_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;
    assign done          = done_q;
    assign sat_flag      = sat_q;
endmodule
